// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   mem_size_t  : funct3 size/sign codes (111 has no member and is illegal)
//   lsu_err_t   : completion status reported on err
//   lsu_state_t : access FSM states
package lsu_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } mem_size_t;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_TIMEOUT    = 2'b10,
    ERR_ILLEGAL    = 2'b11
  } lsu_err_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_t;

  // Lane mask of an access at offset 0: 1, 2, 4 or 8 bytes.
  function automatic logic [7:0] size_lanes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_lanes = 8'h01;
      2'd1:    size_lanes = 8'h03;
      2'd2:    size_lanes = 8'h0F;
      default: size_lanes = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   funct3     in  3  : size/sign code
//   is_store   in  1  : store access (unsigned store codes are illegal)
//   offset     in  3  : addr[2:0]
//   data       in  64 : store operand (store side) or raw read data (load side)
//   be         out 8  : byte enables for the access
//   wdata      out 64 : data shifted into its byte lanes
//   rdata_ext  out 64 : data shifted down and sign/zero extended
//   misaligned out 1  : offset not a multiple of the access size
//   illegal    out 1  : funct3 111, or unsigned code on a store
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [2:0]  offset,
  input  logic [63:0] data,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [63:0] shifted;

  always_comb begin
    be        = size_lanes(funct3[1:0]) << offset;
    wdata     = data << {offset, 3'b000};
    shifted   = data >> {offset, 3'b000};
    illegal   = (funct3 == 3'b111) || (is_store && funct3[2]);

    // An aligned access can never straddle the 8-byte word.
    case (funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase

    case (funct3)
      MEM_B:   rdata_ext = {{56{shifted[7]}},  shifted[7:0]};
      MEM_H:   rdata_ext = {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   rdata_ext = {{32{shifted[31]}}, shifted[31:0]};
      MEM_BU:  rdata_ext = {56'd0, shifted[7:0]};
      MEM_HU:  rdata_ext = {48'd0, shifted[15:0]};
      MEM_WU:  rdata_ext = {32'd0, shifted[31:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit driving a request/grant/response data port.
// Ports:
//   clk, reset (async, active-low)
//   start, is_store, funct3, addr, store_data : access command (sampled in IDLE)
//   busy, done, err, load_data                : status back to the control FSM
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_gnt, mem_rvalid, mem_rdata
//   dbg_state                                 : current FSM state
// Handshake: mem_req is held with stable we/addr/be/wdata until the cycle
// mem_gnt is seen high (transfer accepted); mem_req drops the next cycle.
// Exactly one mem_rvalid per granted request, no earlier than the cycle after
// grant; rvalid outside WAIT is ignored.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [63:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_be,
  output logic [63:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  lsu_state_t        state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [2:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  lsu_err_t          err_q;
  logic [63:0]       load_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_be_q;
  logic [63:0]       mem_wdata_q;

  // One aligner serves both directions: in IDLE it sees the incoming
  // command, afterwards the latched command and the read data.
  logic        idle;
  logic [2:0]  al_f3;
  logic        al_store;
  logic [2:0]  al_off;
  logic [63:0] al_data;
  logic [7:0]  al_be;
  logic [63:0] al_wdata;
  logic [63:0] al_rdata;
  logic        al_misaligned;
  logic        al_illegal;

  always_comb begin
    idle     = (state_q == ST_IDLE);
    al_f3    = idle ? funct3        : funct3_q;
    al_store = idle ? is_store      : is_store_q;
    al_off   = idle ? addr[2:0]     : off_q;
    al_data  = idle ? store_data    : mem_rdata;
  end

  lsu_align u_align (
    .funct3     (al_f3),
    .is_store   (al_store),
    .offset     (al_off),
    .data       (al_data),
    .be         (al_be),
    .wdata      (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (al_illegal || al_misaligned) ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_gnt) state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid || cnt_q == TIMEOUT_C) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latches, timeout counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 3'd0;
      cnt_q       <= '0;
      err_q       <= ERR_OK;
      load_data_q <= 64'd0;
      mem_addr_q  <= '0;
      mem_be_q    <= 8'd0;
      mem_wdata_q <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_store_q  <= is_store;
            funct3_q    <= funct3;
            off_q       <= addr[2:0];
            cnt_q       <= '0;
            mem_addr_q  <= {addr[ADDR_W-1:3], 3'b000};
            mem_be_q    <= al_be;
            mem_wdata_q <= al_wdata;
            // Illegal outranks misaligned.
            if (al_illegal)         err_q <= ERR_ILLEGAL;
            else if (al_misaligned) err_q <= ERR_MISALIGNED;
            else                    err_q <= ERR_OK;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (!is_store_q) load_data_q <= al_rdata;
          end else if (cnt_q == TIMEOUT_C) begin
            err_q <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & is_store_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drivers push expected completions and
// requests into queues, two monitors pop and compare when the DUT shows done
// or a granted request.
module tb_mem_access_unit;

  localparam int ADDR_W  = 64;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       store_data;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [63:0]       load_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_be;
  logic [63:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;
  logic [1:0]        dbg_state;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int start_cyc = 0;
  int req_cycles = 0;

  // {latency[7:0], err[1:0], load_data[63:0]}
  logic [73:0]  exp_q[$];
  // {we, addr[63:0], be[7:0], wdata_masked[63:0]}
  logic [136:0] req_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Completion monitor.
  logic [73:0] mon_e;
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("err", 64'(err), 64'(mon_e[65:64]));
        check("load_data", load_data, mon_e[63:0]);
        check("done_latency", 64'(cyc - start_cyc), 64'(mon_e[73:66]));
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  // Request monitor.
  logic [136:0] mon_r;
  always @(negedge clk) begin
    if (reset && mem_req) begin
      req_cycles++;
      if (mem_gnt) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 64'd1, 64'd0);
        end else begin
          mon_r = req_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(mon_r[136]));
          check("mem_addr", mem_addr, mon_r[135:72]);
          check("mem_be", 64'(mem_be), 64'(mon_r[71:64]));
          if (mon_r[136]) check("mem_wdata", mem_wdata & lane_mask(mem_be), mon_r[63:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // rd < 0 means no response (timeout); bogus adds an rvalid in the grant
  // cycle; poke re-asserts start while the access is in flight.
  task automatic run(input string tag, input logic st, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] sd,
                     input int gd, input int rd, input logic [63:0] rdata,
                     input logic bogus, input logic poke,
                     input logic [1:0] e_err, input logic [63:0] e_ld, input int e_lat,
                     input logic [7:0] e_be, input logic [63:0] e_wd);
    logic legal;
    int n;
    legal = (e_err == 2'b00) || (e_err == 2'b10);
    req_cycles = 0;
    exp_q.push_back({8'(e_lat), e_err, e_ld});
    if (legal) req_q.push_back({st, a & ~64'h7, e_be, e_wd});

    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    start_cyc = cyc;
    @(posedge clk); #1;
    // Scramble the command inputs: the unit must work from its latches.
    start = 1'b0; is_store = ~st; funct3 = ~f3; addr = ~a; store_data = ~sd;
    if (legal) begin
      for (int i = 0; i < gd; i++) begin
        if (poke && i == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      mem_gnt = 1'b1;
      if (bogus) begin mem_rvalid = 1'b1; mem_rdata = ~rdata; end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
      if (rd >= 0) begin
        for (int i = 0; i < rd; i++) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 64'd0;
      end
    end
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_done_seen"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_req_cycles"}, 64'(req_cycles), legal ? 64'(gd + 1) : 64'd0);
    exp_q.delete();
    req_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_load_data"}, load_data, 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0;
    store_data = 64'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    #1;
    check_reset_outputs("rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    //   tag     st f3      addr      store_data              gd rd rdata                  bg pk err   load_data               lat be     wdata
    run("lb",   0, 3'b000, 64'h1003, 64'd0,                  0, 0, 64'h0000_0000_8000_0000, 0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FF80, 3, 8'h08, 64'd0);
    run("lwu",  0, 3'b110, 64'h2004, 64'd0,                  0, 0, 64'h8765_4321_DEAD_BEEF, 0, 0, 2'b00, 64'h0000_0000_8765_4321, 3, 8'hF0, 64'd0);
    run("sh",   1, 3'b001, 64'h3006, 64'h0000_0000_0000_ABCD, 3, 0, 64'd0,                  0, 1, 2'b00, 64'h0000_0000_8765_4321, 6, 8'hC0, 64'hABCD_0000_0000_0000);
    run("sd_mis", 1, 3'b011, 64'h4004, 64'h1111_2222_3333_4444, 0, 0, 64'd0,               0, 0, 2'b01, 64'h0000_0000_8765_4321, 1, 8'h00, 64'd0);
    run("f3_111", 0, 3'b111, 64'h0010, 64'd0,                0, 0, 64'd0,                  0, 0, 2'b11, 64'h0000_0000_8765_4321, 1, 8'h00, 64'd0);
    run("su_ill", 1, 3'b100, 64'h4001, 64'h55,               0, 0, 64'd0,                  0, 0, 2'b11, 64'h0000_0000_8765_4321, 1, 8'h00, 64'd0);
    run("ld",   0, 3'b011, 64'h5000, 64'd0,                  0, 1, 64'h1122_3344_5566_7788, 1, 0, 2'b00, 64'h1122_3344_5566_7788, 4, 8'hFF, 64'd0);
    run("lh",   0, 3'b001, 64'h6002, 64'd0,                  0, 0, 64'h0000_0000_F00D_0000, 0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_F00D, 3, 8'h0C, 64'd0);
    run("lhu",  0, 3'b101, 64'h6002, 64'd0,                  0, 0, 64'h0000_0000_F00D_0000, 0, 0, 2'b00, 64'h0000_0000_0000_F00D, 3, 8'h0C, 64'd0);
    run("lw_to", 0, 3'b010, 64'h7000, 64'd0,                 0, -1, 64'd0,                 0, 0, 2'b10, 64'h0000_0000_0000_F00D, 7, 8'h0F, 64'd0);
    run("sb",   1, 3'b000, 64'h8005, 64'h1234_5678_9ABC_DE5A, 0, 0, 64'd0,                  0, 0, 2'b00, 64'h0000_0000_0000_F00D, 3, 8'h20, 64'h0000_5A00_0000_0000);
    run("sw",   1, 3'b010, 64'h8004, 64'h0000_0000_CAFE_BABE, 1, 2, 64'd0,                  0, 0, 2'b00, 64'h0000_0000_0000_F00D, 6, 8'hF0, 64'hCAFE_BABE_0000_0000);
    run("lw",   0, 3'b010, 64'h8000, 64'd0,                  0, 0, 64'hFFFF_FFFF_8000_0001, 0, 0, 2'b00, 64'hFFFF_FFFF_8000_0001, 3, 8'h0F, 64'd0);

    // Reset in the middle of WAIT.
    req_q.push_back({1'b0, 64'h9000, 8'hFF, 64'd0});
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h9000;
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("mid_in_wait", 64'(dbg_state), 64'd2);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 64'd0;
    repeat (3) begin @(posedge clk); #1; end
    check("late_rvalid_busy", 64'(busy), 64'd0);
    check("late_rvalid_load", load_data, 64'd0);
    req_q.delete();

    run("lb_again", 0, 3'b000, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000, 0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FF80, 3, 8'h08, 64'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle load/store unit sitting directly downstream of the processor control state machine. It consumes the memory-access step of `ld`/`sd`-class instructions: computed address, store operand and `funct3`. It drives a 64-bit request/grant/response data-memory port and returns a sign- or zero-extended load value. It also reports completion, so the control FSM can stall in its memory-access states until `done`.

## Interface
Parameters:
- `ADDR_W`, default 64: byte-address width.
- `TIMEOUT`, default 255: number of WAIT cycles without `mem_rvalid` before aborting. Must be ≥1.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `start` in 1: begin an access; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: size/sign code from the instruction.
- `addr` in ADDR_W: byte address (ALU output).
- `store_data` in 64: register-B operand.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 2: completion status, valid with `done`, held until next `start`. 00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- `load_data` out 64: extended load result; holds until the next successful load.
- `mem_req` out 1: request valid.
- `mem_we` out 1: write request.
- `mem_addr` out ADDR_W: `addr` with bits [2:0] forced to 0.
- `mem_be` out 8: byte enables.
- `mem_wdata` out 64: lane-aligned store data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: response (read data or write ack).
- `mem_rdata` in 64: read data.

## Operation
- **funct3 sizes:**
  - 000 B, 001 H, 010 W, 011 D: signed.
  - 100 BU, 101 HU, 110 WU: unsigned.
  - 111 is illegal.
  - A store with funct3[2]=1 is illegal.
- **Misalignment:** `addr` not a multiple of the access size. Crossing an 8-byte boundary is therefore impossible.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - On `start`: latch `is_store`, `funct3`, `addr` and `store_data`, and clear `err`.
  - If illegal or misaligned, go to DONE with `err` = 11 or 01, issuing no memory traffic. Illegal takes priority over misaligned.
  - Otherwise go to REQ.
- **REQ:**
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` stable from latched values.
  - On `mem_gnt`, go to WAIT.
  - `mem_req` drops in the cycle after `mem_gnt`.
- **WAIT:**
  - Timeout counter increments each cycle.
  - A response is legal no earlier than the cycle after grant. `mem_rvalid` in the grant cycle is ignored.
  - On `mem_rvalid`, for a load: `load_data` ← extend(`mem_rdata` >> 8·addr[2:0]). Then go to DONE with `err`=00.
  - If the counter reaches TIMEOUT with no `mem_rvalid`, go to DONE with `err`=10; `load_data` is unchanged.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Byte lanes:**
  - `mem_be` = (2^size−1) << addr[2:0].
  - `mem_wdata` = `store_data` << 8·addr[2:0]; unused lanes are don't-care.
- **`start` while busy:** ignored, not queued.
- **`mem_rvalid` in IDLE/REQ/DONE:** ignored.

## Timing
- **Reset values:** state IDLE, `busy`/`done`/`mem_req`/`mem_we`=0, `mem_be`=0, `mem_addr`/`mem_wdata`=0, `err`=00, `load_data`=0, counter 0.
- **Reset mid-operation:** returns to IDLE immediately and asynchronously, with `mem_req` deasserted. A late response is ignored.
- **Best-case latency** (gnt in the first REQ cycle, rvalid the next cycle):
  - `start` at cycle 0, REQ cycle 1, WAIT cycle 2, `done` cycle 3.
  - `load_data` is valid from cycle 3.
- **Fault path:** illegal/misaligned gives `done` at cycle 1.
- **Timeout path:** `done` occurs TIMEOUT+1 cycles after entering WAIT.
- **Back-to-back:** the earliest accepted new `start` is in the cycle after `done` (IDLE).

## Structure
- Shared package `lsu_pkg`:
  - `mem_size_t` funct3 constants (B, H, W, D, BU, HU, WU).
  - `lsu_err_t` (OK, MISALIGNED, TIMEOUT, ILLEGAL).
  - `lsu_state_t` enum.
- Sub-module `lsu_align`, purely combinational:
  - Given funct3, offset and data, produces `mem_be`, shifted `mem_wdata`, extended load value, `misaligned` and `illegal`.
- `mem_access_unit` holds the FSM, latches, counter and output registers.

## Test plan
- **LB sign-extend:** LB at addr 0x1003, rdata 0x0000_0000_8000_0000 (byte 3 = 0x80) → `mem_addr` 0x1000, `mem_be` 0x08, `load_data` 0xFFFF_FFFF_FFFF_FF80, `err` 00, `done` at cycle 3.
- **LWU zero-extend:** LWU at addr 0x2004, rdata 0x8765_4321_xxxx_xxxx → `load_data` 0x0000_0000_8765_4321.
- **SH store:** SH at addr 0x3006, `store_data` 0xABCD → `mem_we`=1, `mem_be` 0xC0, `mem_wdata`[63:48]=0xABCD. `mem_req` is held through 3 cycles of `mem_gnt`=0 and drops after grant.
- **Faults:**
  - SD at addr 0x4004 → `err` 01, `done` at cycle 1, `mem_req` never asserted.
  - funct3=111 → `err` 11.
- **Timeout:** TIMEOUT=4, grant given but no rvalid → `done` with `err` 10 five cycles after WAIT entry; `load_data` retains its prior value.
- **Reset mid-operation:** `reset` low during WAIT → all outputs at reset values immediately. A following rvalid produces no `done`, and a new `start` after release completes normally.
